// File: rtl/id_ex_ctrl_stage.sv
// ---------------------------------------------------------------------------
// id_ex_ctrl_stage
//
// ID/EX control stage of a MIPS-like pipeline. Decodes the opcode held in
// IF/ID into a registered control bundle and handles three kinds of stall:
// a downstream hold, a load-use hazard against the instruction currently in
// EX, and a multi-cycle multiply that occupies EX for MUL_LAT cycles.
//
// Parameters
//   REG_AW   register-address width (3..6)
//   MUL_LAT  total multiply occupancy in cycles (2..15)
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   IF/ID handshake; in_ready is combinational
//   op_code             6-bit opcode
//   in_rs/in_rt/in_rd   register fields of the ID instruction
//   ex_hold             downstream stall, freezes everything
//   flush               taken branch, drop the ID instruction
//   out_valid           ID/EX holds a real instruction (0 = bubble)
//   reg_dst .. branch   registered single-bit controls
//   alu_op, load_mode   registered multi-bit controls
//   ex_dst              registered destination register (rd or rt)
//   mul_busy            a multiply is still occupying EX
// ---------------------------------------------------------------------------
module id_ex_ctrl_stage #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op_code,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              out_valid,
    output logic              reg_dst,
    output logic              reg_write,
    output logic              alu_src,
    output logic              mem_write,
    output logic              mem_read,
    output logic              mem_to_reg,
    output logic              branch,
    output logic [2:0]        alu_op,
    output logic [1:0]        load_mode,
    output logic [REG_AW-1:0] ex_dst,
    output logic              mul_busy
);

    localparam int unsigned CntW = $clog2(MUL_LAT + 1);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpLh    = 6'b100001;
    localparam logic [5:0] OpLhu   = 6'b100101;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpMul   = 6'b011100;

    typedef enum logic {StRun, StMulWait} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              out_valid_q, out_valid_d;
    logic              reg_dst_q, reg_dst_d;
    logic              reg_write_q, reg_write_d;
    logic              alu_src_q, alu_src_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              branch_q, branch_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [1:0]        load_mode_q, load_mode_d;
    logic [REG_AW-1:0] ex_dst_q, ex_dst_d;

    // Decoded bundle for the instruction currently in ID.
    logic              dec_reg_dst, dec_reg_write, dec_alu_src, dec_mem_write;
    logic              dec_mem_read, dec_mem_to_reg, dec_branch, dec_uses_rt, dec_is_mul;
    logic [2:0]        dec_alu_op;
    logic [1:0]        dec_load_mode;
    logic              hazard;

    always_comb begin
        dec_reg_dst    = 1'b0;
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_to_reg = 1'b1;
        dec_branch     = 1'b0;
        dec_alu_op     = 3'b000;
        dec_load_mode  = 2'b00;
        dec_uses_rt    = 1'b0;
        dec_is_mul     = 1'b0;
        unique case (op_code)
            OpRtype: begin
                dec_reg_dst = 1'b1;
                dec_alu_op  = 3'b100;
                dec_uses_rt = 1'b1;
            end
            OpAddi: dec_alu_src = 1'b1;
            OpLw, OpLh, OpLhu: begin
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b0;
                dec_load_mode  = (op_code == OpLh)  ? 2'b01 :
                                 (op_code == OpLhu) ? 2'b10 : 2'b00;
            end
            OpSw: begin
                dec_reg_write = 1'b0;
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OpBeq: begin
                dec_reg_write = 1'b0;
                dec_alu_op    = 3'b001;
                dec_branch    = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OpAndi: begin
                dec_alu_src = 1'b1;
                dec_alu_op  = 3'b011;
            end
            OpOri: begin
                dec_alu_src = 1'b1;
                dec_alu_op  = 3'b010;
            end
            OpMul: begin
                dec_reg_dst = 1'b1;
                dec_alu_op  = 3'b101;
                dec_uses_rt = 1'b1;
                dec_is_mul  = 1'b1;
            end
            // Unknown opcodes travel down the pipe as a valid NOP.
            default: dec_reg_write = 1'b0;
        endcase
    end

    // Only rt-reading formats can hazard on rt; immediates overwrite rt instead.
    assign hazard = in_valid & out_valid_q & mem_read_q & (ex_dst_q != '0) &
                    ((ex_dst_q == in_rs) | ((ex_dst_q == in_rt) & dec_uses_rt));

    // Flush consumes the instruction (to drop it), so it readies even mid-multiply.
    assign in_ready = ~ex_hold & (flush | ((state_q == StRun) & ~hazard));

    always_comb begin
        // Default: hold everything (ex_hold case).
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        reg_dst_d    = reg_dst_q;
        reg_write_d  = reg_write_q;
        alu_src_d    = alu_src_q;
        mem_write_d  = mem_write_q;
        mem_read_d   = mem_read_q;
        mem_to_reg_d = mem_to_reg_q;
        branch_d     = branch_q;
        alu_op_d     = alu_op_q;
        load_mode_d  = load_mode_q;
        ex_dst_d     = ex_dst_q;

        if (!ex_hold) begin
            // Bubble unless the accept branch below overrides.
            out_valid_d  = 1'b0;
            reg_dst_d    = 1'b0;
            reg_write_d  = 1'b0;
            alu_src_d    = 1'b0;
            mem_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_to_reg_d = 1'b0;
            branch_d     = 1'b0;
            alu_op_d     = 3'b000;
            load_mode_d  = 2'b00;
            ex_dst_d     = '0;

            if (flush) begin
                state_d = StRun;
                cnt_d   = '0;
            end else if (state_q == StMulWait) begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StRun;
                end
            end else if (!hazard && in_valid) begin
                out_valid_d  = 1'b1;
                reg_dst_d    = dec_reg_dst;
                reg_write_d  = dec_reg_write;
                alu_src_d    = dec_alu_src;
                mem_write_d  = dec_mem_write;
                mem_read_d   = dec_mem_read;
                mem_to_reg_d = dec_mem_to_reg;
                branch_d     = dec_branch;
                alu_op_d     = dec_alu_op;
                load_mode_d  = dec_load_mode;
                ex_dst_d     = dec_reg_dst ? in_rd : in_rt;
                if (dec_is_mul) begin
                    state_d = StMulWait;
                    cnt_d   = CntW'(MUL_LAT - 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            branch_q     <= 1'b0;
            alu_op_q     <= 3'b000;
            load_mode_q  <= 2'b00;
            ex_dst_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            reg_dst_q    <= reg_dst_d;
            reg_write_q  <= reg_write_d;
            alu_src_q    <= alu_src_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            mem_to_reg_q <= mem_to_reg_d;
            branch_q     <= branch_d;
            alu_op_q     <= alu_op_d;
            load_mode_q  <= load_mode_d;
            ex_dst_q     <= ex_dst_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign reg_dst    = reg_dst_q;
    assign reg_write  = reg_write_q;
    assign alu_src    = alu_src_q;
    assign mem_write  = mem_write_q;
    assign mem_read   = mem_read_q;
    assign mem_to_reg = mem_to_reg_q;
    assign branch     = branch_q;
    assign alu_op     = alu_op_q;
    assign load_mode  = load_mode_q;
    assign ex_dst     = ex_dst_q;
    assign mul_busy   = (state_q == StMulWait);

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// ---------------------------------------------------------------------------
// Testbench for id_ex_ctrl_stage (REG_AW=5, MUL_LAT=4).
// Inputs change on the falling edge; in_ready is sampled 1 ns later and the
// registered outputs 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_id_ex_ctrl_stage;

    localparam int unsigned AW  = 5;
    localparam int unsigned LAT = 4;

    typedef struct packed {
        logic          ov;
        logic          rdst;
        logic          rw;
        logic          asrc;
        logic          mw;
        logic          mr;
        logic          m2r;
        logic          br;
        logic [2:0]    alu;
        logic [1:0]    lm;
        logic [AW-1:0] dst;
    } ctrl_t;

    typedef struct {
        string         name;
        logic [5:0]    op;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        ctrl_t         exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    op_code;
    logic [AW-1:0] in_rs, in_rt, in_rd;
    logic          ex_hold, flush;
    logic          out_valid, reg_dst, reg_write, alu_src, mem_write, mem_read;
    logic          mem_to_reg, branch, mul_busy;
    logic [2:0]    alu_op;
    logic [1:0]    load_mode;
    logic [AW-1:0] ex_dst;

    int n_cmp  = 0;
    int n_fail = 0;

    id_ex_ctrl_stage #(
        .REG_AW (AW),
        .MUL_LAT(LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_code   (op_code),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .ex_hold   (ex_hold),
        .flush     (flush),
        .out_valid (out_valid),
        .reg_dst   (reg_dst),
        .reg_write (reg_write),
        .alu_src   (alu_src),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_to_reg(mem_to_reg),
        .branch    (branch),
        .alu_op    (alu_op),
        .load_mode (load_mode),
        .ex_dst    (ex_dst),
        .mul_busy  (mul_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ctrl_t mk(input logic ov, input logic rdst, input logic rw,
                                 input logic asrc, input logic mw, input logic mr,
                                 input logic m2r, input logic br, input logic [2:0] alu,
                                 input logic [1:0] lm, input logic [AW-1:0] dst);
        ctrl_t c;
        c = '{ov, rdst, rw, asrc, mw, mr, m2r, br, alu, lm, dst};
        return c;
    endfunction

    function automatic ctrl_t dut_o();
        ctrl_t c;
        c = '{out_valid, reg_dst, reg_write, alu_src, mem_write, mem_read, mem_to_reg,
              branch, alu_op, load_mode, ex_dst};
        return c;
    endfunction

    // Reference decode straight from the opcode table.
    function automatic ctrl_t ref_decode(input logic [5:0] op, input logic [AW-1:0] rt,
                                         input logic [AW-1:0] rd);
        ctrl_t c;
        c = '0;
        c.ov = 1'b1; c.rw = 1'b1; c.m2r = 1'b1;
        case (op)
            6'b000000: begin c.rdst = 1'b1; c.alu = 3'b100; end
            6'b001000: c.asrc = 1'b1;
            6'b100011: begin c.asrc = 1'b1; c.mr = 1'b1; c.m2r = 1'b0; end
            6'b100001: begin c.asrc = 1'b1; c.mr = 1'b1; c.m2r = 1'b0; c.lm = 2'b01; end
            6'b100101: begin c.asrc = 1'b1; c.mr = 1'b1; c.m2r = 1'b0; c.lm = 2'b10; end
            6'b101011: begin c.rw = 1'b0; c.asrc = 1'b1; c.mw = 1'b1; end
            6'b000100: begin c.rw = 1'b0; c.alu = 3'b001; c.br = 1'b1; end
            6'b001100: begin c.asrc = 1'b1; c.alu = 3'b011; end
            6'b001101: begin c.asrc = 1'b1; c.alu = 3'b010; end
            6'b011100: begin c.rdst = 1'b1; c.alu = 3'b101; end
            default:   c.rw = 1'b0;
        endcase
        c.dst = c.rdst ? rd : rt;
        return c;
    endfunction

    function automatic logic reads_rt(input logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b101011) || (op == 6'b000100) ||
               (op == 6'b011100);
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic hold, input logic fl);
        in_valid = v; op_code = op; in_rs = rs; in_rt = rt; in_rd = rd;
        ex_hold = hold; flush = fl;
    endtask

    vec_t vecs[11];

    // Reference model state: last loaded bundle and remaining multiply cycles.
    ctrl_t m_out;
    int    m_rem;

    initial begin
        logic [5:0] oplist[11];
        logic       hz, exp_rdy;

        vecs[0]  = '{"rtype", 6'b000000, 5'd1, 5'd2, 5'd3, mk(1,1,1,0,0,0,1,0,3'b100,2'b00,5'd3)};
        vecs[1]  = '{"addi",  6'b001000, 5'd1, 5'd2, 5'd3, mk(1,0,1,1,0,0,1,0,3'b000,2'b00,5'd2)};
        vecs[2]  = '{"lw",    6'b100011, 5'd1, 5'd2, 5'd3, mk(1,0,1,1,0,1,0,0,3'b000,2'b00,5'd2)};
        vecs[3]  = '{"lh",    6'b100001, 5'd1, 5'd2, 5'd3, mk(1,0,1,1,0,1,0,0,3'b000,2'b01,5'd2)};
        vecs[4]  = '{"lhu",   6'b100101, 5'd1, 5'd2, 5'd3, mk(1,0,1,1,0,1,0,0,3'b000,2'b10,5'd2)};
        vecs[5]  = '{"sw",    6'b101011, 5'd1, 5'd2, 5'd3, mk(1,0,0,1,1,0,1,0,3'b000,2'b00,5'd2)};
        vecs[6]  = '{"beq",   6'b000100, 5'd1, 5'd2, 5'd3, mk(1,0,0,0,0,0,1,1,3'b001,2'b00,5'd2)};
        vecs[7]  = '{"andi",  6'b001100, 5'd1, 5'd2, 5'd3, mk(1,0,1,1,0,0,1,0,3'b011,2'b00,5'd2)};
        vecs[8]  = '{"ori",   6'b001101, 5'd1, 5'd2, 5'd3, mk(1,0,1,1,0,0,1,0,3'b010,2'b00,5'd2)};
        vecs[9]  = '{"mul",   6'b011100, 5'd1, 5'd2, 5'd3, mk(1,1,1,0,0,0,1,0,3'b101,2'b00,5'd3)};
        vecs[10] = '{"nop",   6'b111111, 5'd1, 5'd2, 5'd3, mk(1,0,0,0,0,0,1,0,3'b000,2'b00,5'd2)};
        for (int i = 0; i < 11; i++) oplist[i] = vecs[i].op;

        // ---------------- reset ----------------
        reset = 1'b1;
        drive(0, 6'b0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", dut_o(), '0);
        chk("reset_mul_busy", mul_busy, 0);
        @(negedge clk) reset = 1'b0;
        #1 chk("reset_in_ready", in_ready, 1);

        // ---------------- decode table ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, 0, 0);
            #1 chk({"ready_", vecs[i].name}, in_ready, 1);
            @(posedge clk);
            #1 chk({"dec_", vecs[i].name}, dut_o(), vecs[i].exp);
            @(negedge clk);
            drive(0, 6'b0, 0, 0, 0, 0, 0);
            repeat (LAT) @(posedge clk);
        end
        #1 chk("idle_bubble", dut_o(), '0);

        // ---------------- load-use stall ----------------
        @(negedge clk); drive(1, 6'b100011, 5'd1, 5'd5, 5'd0, 0, 0);
        @(posedge clk); #1 chk("lu_lw_out", dut_o(), mk(1,0,1,1,0,1,0,0,3'b000,2'b00,5'd5));
        @(negedge clk); drive(1, 6'b000000, 5'd5, 5'd6, 5'd7, 0, 0);
        #1 chk("lu_stall_ready", in_ready, 0);
        @(posedge clk); #1 chk("lu_bubble", dut_o(), '0);
        @(negedge clk); #1 chk("lu_retry_ready", in_ready, 1);
        @(posedge clk); #1 chk("lu_add_out", dut_o(), mk(1,1,1,0,0,0,1,0,3'b100,2'b00,5'd7));

        // ---------------- load to r0: no stall ----------------
        @(negedge clk); drive(1, 6'b100011, 5'd1, 5'd0, 5'd0, 0, 0);
        @(posedge clk); #1 chk("r0_lw_ov", out_valid, 1);
        @(negedge clk); drive(1, 6'b000000, 5'd0, 5'd0, 5'd9, 0, 0);
        #1 chk("r0_ready", in_ready, 1);
        @(posedge clk); #1 chk("r0_add_out", dut_o(), mk(1,1,1,0,0,0,1,0,3'b100,2'b00,5'd9));

        // ---------------- multiply occupancy ----------------
        @(negedge clk); drive(1, 6'b011100, 5'd1, 5'd2, 5'd4, 0, 0);
        @(posedge clk);
        @(negedge clk); drive(1, 6'b000000, 5'd1, 5'd2, 5'd8, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mul_busy", mul_busy, 1);
            chk("mul_ready", in_ready, 0);
            chk("mul_ov", out_valid, (k == 0));
            if (k == 0) chk("mul_alu", alu_op, 3'b101);
            @(negedge clk);
        end
        #1 chk("mul_done_busy", mul_busy, 0);
        chk("mul_done_ready", in_ready, 1);
        @(posedge clk); #1 chk("mul_next_out", dut_o(), mk(1,1,1,0,0,0,1,0,3'b100,2'b00,5'd8));

        // ---------------- flush during multiply ----------------
        @(negedge clk); drive(1, 6'b011100, 5'd1, 5'd2, 5'd4, 0, 0);
        @(posedge clk);
        @(negedge clk); drive(0, 6'b0, 0, 0, 0, 0, 0);
        @(posedge clk);   // cnt now 2
        @(negedge clk); drive(1, 6'b001000, 5'd1, 5'd2, 5'd3, 0, 1);
        #1 chk("flush_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("flush_busy", mul_busy, 0);
        chk("flush_bubble", dut_o(), '0);
        @(negedge clk); drive(0, 6'b0, 0, 0, 0, 0, 0);
        #1 chk("flush_after_ready", in_ready, 1);

        // ---------------- ex_hold freezes LH ----------------
        @(negedge clk); drive(1, 6'b100001, 5'd1, 5'd4, 5'd0, 0, 0);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(1, 6'b001101, 5'd2, 5'd3, 5'd0, 1, 0);
            #1 chk("hold_ready", in_ready, 0);
            @(posedge clk);
            #1 chk("hold_frozen", dut_o(), mk(1,0,1,1,0,1,0,0,3'b000,2'b01,5'd4));
        end
        @(negedge clk); ex_hold = 1'b0;
        #1 chk("hold_release_ready", in_ready, 1);
        @(posedge clk); #1 chk("hold_ori_out", dut_o(), mk(1,0,1,1,0,0,1,0,3'b010,2'b00,5'd3));

        // ---------------- reset mid-multiply ----------------
        @(negedge clk); drive(1, 6'b011100, 5'd1, 5'd2, 5'd4, 0, 0);
        @(posedge clk);
        @(negedge clk); #2;
        drive(1, 6'b111111, 5'd1, 5'd2, 5'd3, 0, 0);
        reset = 1'b1;
        #1;
        chk("rst_async_bubble", dut_o(), '0);
        chk("rst_async_busy", mul_busy, 0);
        repeat (2) @(posedge clk);
        #1 chk("rst_hold_bubble", dut_o(), '0);
        @(negedge clk) reset = 1'b0;
        #1 chk("rst_release_ready", in_ready, 1);
        @(posedge clk); #1 chk("rst_nop_out", dut_o(), mk(1,0,0,0,0,0,1,0,3'b000,2'b00,5'd2));

        // ---------------- randomized vs reference model ----------------
        @(negedge clk); drive(0, 6'b0, 0, 0, 0, 0, 0); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        m_out = '0;
        m_rem = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [5:0] op;
            int         sel;
            @(negedge clk);
            sel = $urandom_range(0, 11);
            op  = (sel == 11) ? 6'($urandom_range(0, 63)) : oplist[sel];
            drive(($urandom_range(0, 3) != 0), op, AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
            hz = in_valid && m_out.ov && m_out.mr && (m_out.dst != 0) &&
                 ((m_out.dst == in_rs) || ((m_out.dst == in_rt) && reads_rt(op_code)));
            exp_rdy = !ex_hold && (flush || (m_rem == 0 && !hz));
            #1 chk("rand_ready", in_ready, exp_rdy);
            @(posedge clk);
            if (!ex_hold) begin
                if (flush) begin
                    m_out = '0; m_rem = 0;
                end else if (m_rem > 0) begin
                    m_out = '0; m_rem--;
                end else if (hz || !in_valid) begin
                    m_out = '0;
                end else begin
                    m_out = ref_decode(op_code, in_rt, in_rd);
                    if (op_code == 6'b011100) m_rem = LAT - 1;
                end
            end
            #1;
            chk("rand_out", dut_o(), m_out);
            chk("rand_busy", mul_busy, (m_rem > 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl_stage.md
ID_EX_CTRL_STAGE -- requirements
Module: id_ex_ctrl_stage

Interface
REQ-001 Parameter REG_AW, default 5, register-address width; legal range 3..6.
REQ-002 Parameter MUL_LAT, default 4, total MUL occupancy in cycles; legal range 2..15.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port in_valid  in  1  IF/ID holds a valid instruction.
REQ-006 Port in_ready  out  1  stage accepts the instruction this cycle.
REQ-007 Port op_code  in  6  instruction opcode.
REQ-008 Ports in_rs, in_rt, in_rd  in  REG_AW each  source/destination register fields.
REQ-009 Port ex_hold  in  1  downstream stall; freezes the stage.
REQ-010 Port flush  in  1  taken branch; discard the current ID instruction.
REQ-011 Port out_valid  out  1  ID/EX register holds a real instruction, not a bubble.
REQ-012 Ports reg_dst, reg_write, alu_src, mem_write, mem_read, mem_to_reg, branch  out  1 each  registered controls.
REQ-013 Ports alu_op  out  3, load_mode  out  2, ex_dst  out  REG_AW  registered; ex_dst = in_rd if reg_dst else in_rt.
REQ-014 Port mul_busy  out  1  high while the FSM is in MUL_WAIT.

Function
REQ-015 Decode SHALL follow this table; unlisted fields use defaults: reg_write=1, alu_src=0, mem_write=0, mem_read=0, mem_to_reg=1 (1 = ALU result), load_mode=00, branch=0.
 - 000000 R-type: reg_dst=1, alu_op=100.
 - 001000 ADDI: alu_src=1, alu_op=000.
 - 100011/100001/100101 LW/LH/LHU: alu_src=1, alu_op=000, mem_read=1, mem_to_reg=0, load_mode=00/01/10.
 - 101011 SW: reg_write=0, alu_src=1, alu_op=000, mem_write=1.
 - 000100 BEQ: reg_write=0, alu_op=001, branch=1.
 - 001100 ANDI: alu_src=1, alu_op=011.
 - 001101 ORI: alu_src=1, alu_op=010.
 - 011100 MUL (new): reg_dst=1, alu_op=101.
 - Other: reg_write=0, reg_dst=0, alu_op=000; out_valid still 1 (NOP).
REQ-016 reg_dst=0 for every opcode that does not set it.
REQ-017 Bubble SHALL be: out_valid=0, reg_write=0, mem_write=0, mem_read=0, branch=0, all other control outputs 0.
REQ-018 Load-use hazard SHALL be: in_valid & out_valid & mem_read & ex_dst!=0 & (ex_dst==in_rs | (ex_dst==in_rt & op_code in {R-type, SW, BEQ, MUL})).
REQ-019 FSM states SHALL be RUN and MUL_WAIT, with a down-counter cnt of width ceil(log2(MUL_LAT+1)).
REQ-020 Per-edge priority SHALL be: ex_hold > flush > MUL_WAIT > load-use > accept.
REQ-021 When ex_hold=1, all registers, state and cnt SHALL hold, and in_ready=0.
REQ-022 When flush=1 and ex_hold=0, the stage SHALL load a bubble, go to RUN, clear cnt, and drive in_ready=1 so the instruction is consumed and dropped.
REQ-023 In MUL_WAIT, the stage SHALL load a bubble, drive in_ready=0, and decrement cnt; it SHALL go to RUN on the edge where cnt==1.
REQ-024 On load-use in RUN, the stage SHALL load a bubble and drive in_ready=0.
REQ-025 On accept (RUN, in_valid, no hazard), the stage SHALL load the decoded bundle and set out_valid=1; on MUL, it SHALL go to MUL_WAIT with cnt=MUL_LAT-1.
REQ-026 With in_valid=0 in RUN, the stage SHALL load a bubble and drive in_ready=1.
REQ-027 in_ready SHALL be combinational from current state and inputs and SHALL NOT depend on in_ready itself.
REQ-028 Latency SHALL be one cycle from accept to the registered outputs.

Reset
REQ-029 Reset SHALL asynchronously force state RUN, cnt=0, and all registered outputs to bubble values (REQ-017), with ex_dst=0.
REQ-030 Reset asserted during MUL_WAIT SHALL abort the multiply; after release, in_ready=1 on the first cycle.

Verification
REQ-031 The bench SHALL drive LW (100011, rt=5), then ADD (000000, rs=5) -> one bubble cycle with in_ready=0, then ADD issues with reg_dst=1, alu_op=100.
REQ-032 The bench SHALL drive LW rt=0, then ADD rs=0 -> no stall, back-to-back issue.
REQ-033 The bench SHALL drive MUL with MUL_LAT=4 -> out_valid=1 alu_op=101 for 1 cycle, then mul_busy=1 and in_ready=0 for 3 cycles, then RUN.
REQ-034 The bench SHALL assert flush during MUL_WAIT with cnt=2 -> next cycle RUN, mul_busy=0, bubble.
REQ-035 The bench SHALL assert ex_hold for 3 cycles holding LH -> outputs frozen with load_mode=01, in_ready=0; on release the next instruction issues.
REQ-036 The bench SHALL assert reset mid-stream, then drive opcode 111111 -> bubble during reset; after release, out_valid=1 with reg_write=0 and alu_op=000.
